// File: rtl/shift_deser.sv
// shift_deser: serial-in / parallel-out deserializer.
// Collects WIDTH bits qualified by bit_valid into a word, MSB-first or
// LSB-first. Completed words go out on data_out with a valid/ready
// handshake. The sticky overrun flag records any word that was dropped.
module shift_deser #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             msb_first,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic [CNTW-1:0]  bit_count,
    output logic             busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

    state_t           state;
    logic             dir_q;
    logic [WIDTH-1:0] shreg;

    logic             acc;
    logic             dir_eff;
    logic             last_bit;
    logic [WIDTH-1:0] shifted;

    // A bit is taken only when enabled, valid, and not being aborted.
    assign acc = enable & bit_valid & ~clear;

    // The first bit of a word uses the live msb_first; later bits use the
    // direction latched at word start, so mid-word toggles are ignored.
    assign dir_eff = (state == IDLE) ? msb_first : dir_q;

    // The shift register is zero at word start, so one shift expression
    // covers both the first bit and every later bit.
    assign shifted = dir_eff ? {shreg[WIDTH-2:0], serial_in}
                             : {serial_in, shreg[WIDTH-1:1]};

    // The WIDTH-th accepted bit completes the word.
    assign last_bit = (state == SHIFT) && (bit_count == LAST_CNT);

    assign busy = (state == SHIFT);

    // Bit collection FSM plus registered word output, handshake and overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dir_q      <= 1'b0;
            shreg      <= '0;
            bit_count  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Collection side: clear aborts the partial word.
            if (clear) begin
                state     <= IDLE;
                shreg     <= '0;
                bit_count <= '0;
            end else if (acc) begin
                case (state)
                    IDLE: begin
                        dir_q     <= msb_first;
                        shreg     <= shifted;
                        bit_count <= CNTW'(1);
                        state     <= SHIFT;
                    end
                    SHIFT: begin
                        if (last_bit) begin
                            shreg     <= '0;
                            bit_count <= '0;
                            state     <= IDLE;
                        end else begin
                            shreg     <= shifted;
                            bit_count <= bit_count + CNTW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // Output side: a completed word loads if the slot is free or is
            // being consumed at this same edge; otherwise the word is dropped.
            if (acc && last_bit) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shifted;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            // clear never coincides with a completion, because acc is then 0.
            if (clear) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
